garage_door_actuator: RTL and testbench
=======================================

GARAGE_DOOR_ACTUATOR -- requirements
Module: garage_door_actuator

Interface
REQ-001 Parameter TRAVEL_STEPS, default 16: position steps between fully closed (0) and fully open (TRAVEL_STEPS), minimum 2.
REQ-002 Parameter STEP_CYCLES, default 4: clock cycles of continuous motor drive per position step, minimum 1.
REQ-003 Derived width POS_W SHALL be ceil(log2(TRAVEL_STEPS+1)).
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 RST  input  1  synchronous reset, active-high.
REQ-006 UP_M  input  1  raise-motor command from the door controller.
REQ-007 DN_M  input  1  lower-motor command from the door controller.
REQ-008 UP_Max  output  1  upper limit switch, high when Position == TRAVEL_STEPS.
REQ-009 DN_Max  output  1  lower limit switch, high when Position == 0.
REQ-010 Position  output  POS_W  current door position, registered.
REQ-011 Moving  output  1  high when a step count is in progress.
REQ-012 Fault  output  1  high while both motor commands are asserted together.

Function
REQ-013 Block SHALL model the door plant driven by the garage door controller, closing the loop UP_M/DN_M -> UP_Max/DN_Max.
REQ-014 State machine SHALL have states IDLE, RAISING, LOWERING, FAULT; next state SHALL be decided from UP_M, DN_M, and Position sampled each edge.
REQ-015 UP_M=1, DN_M=0, Position<TRAVEL_STEPS -> RAISING; DN_M=1, UP_M=0, Position>0 -> LOWERING; UP_M=DN_M=1 -> FAULT; otherwise -> IDLE.
REQ-016 A step prescaler SHALL count 0..STEP_CYCLES-1 on each edge in which the next state is RAISING or LOWERING; on terminal count Position SHALL change by +1 (raising) or -1 (lowering) and the prescaler SHALL clear on the same edge.
REQ-017 Latency: with UP_M held from Position=0, Position SHALL be 1 after exactly STEP_CYCLES edges and TRAVEL_STEPS after exactly TRAVEL_STEPS*STEP_CYCLES edges.
REQ-018 UP_Max, DN_Max SHALL be registered and SHALL update on the same edge as the Position change that causes them.
REQ-019 Position SHALL saturate: never exceed TRAVEL_STEPS, never go below 0, never wrap; a command toward a limit already reached SHALL leave Position and prescaler unchanged and Moving=0.
REQ-020 Command released mid-step (IDLE) SHALL clear the prescaler; partial steps SHALL be discarded, Position held.
REQ-021 Direction reversal (RAISING to LOWERING or back in one edge) SHALL clear the prescaler; the new direction SHALL need a full STEP_CYCLES for its first step.
REQ-022 FAULT: Fault=1 from the edge both commands are sampled high; Position held, prescaler cleared, Moving=0.
REQ-023 FAULT SHALL exit on the first edge where UP_M and DN_M are not both high, going directly to the state of REQ-015; Fault SHALL fall on that edge.
REQ-024 Moving SHALL be 1 exactly in RAISING or LOWERING.

Reset
REQ-025 RST=1 at an edge SHALL set state IDLE, Position=0, prescaler=0, DN_Max=1, UP_Max=0, Moving=0, Fault=0, overriding all inputs.
REQ-026 Reset asserted mid-travel or in FAULT SHALL give the REQ-025 values on that edge; no partial step SHALL survive.
REQ-027 No asynchronous path from RST to any flop.

Structure
REQ-028 Package garage_door_pkg SHALL hold the state encoding (IDLE, RAISING, LOWERING, FAULT) and defaults for TRAVEL_STEPS and STEP_CYCLES.
REQ-029 Prescaler SHALL be a sub-module door_step_timer (inputs enable and clear; output terminal-count pulse), parameterised by STEP_CYCLES.
REQ-030 Outputs SHALL be driven from flops only; no combinational input-to-output path.

Verification
REQ-031 Reset, then UP_M=1 for 64 cycles (defaults) -> Position 1 at cycle 4, 16 at cycle 64, UP_Max=1, DN_Max=0, Moving=0 from cycle 64.
REQ-032 At Position 16, keep UP_M=1 for 20 more cycles -> Position stays 16, no wrap, Moving=0.
REQ-033 From 16, DN_M=1 for 6 cycles, then UP_M=1 -> Position 15 at cycle 4; reversal clears prescaler, Position 16 exactly 4 cycles after UP_M.
REQ-034 Midway, UP_M=DN_M=1 for 3 cycles -> Fault=1 next edge, Position frozen; release to DN_M only -> Fault=0, lowering resumes with a full 4-cycle step.
REQ-035 RST=1 for one cycle while raising at Position 9 -> next edge Position=0, DN_Max=1, UP_Max=0, Fault=0, Moving=0.
REQ-036 Closed loop with the garage door controller: Activate pulse at closed -> door opens to UP_Max in 64 cycles and controller drops UP_M; second Activate -> closes to DN_Max.

Source files
------------

// File: rtl/garage_door_pkg.sv
// garage_door_pkg: shared state encoding and default geometry for the door plant model
package garage_door_pkg;
  typedef enum logic [1:0] {IDLE, RAISING, LOWERING, FAULT} door_state_t;
  localparam int TRAVEL_STEPS_DEF = 16;
  localparam int STEP_CYCLES_DEF = 4;
endpackage

// File: rtl/door_step_timer.sv
// door_step_timer: counts motor-drive cycles and pulses tc when a full position step completes
module door_step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tc
);
  localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
  logic [CW-1:0] cnt, base;
  // clear discards the partial step but still lets this edge count as the first drive cycle
  assign base = clear ? '0 : cnt;
  assign tc = enable && base == LAST;
  // count while driven; idle, terminal count and reset all return to zero
  always_ff @(posedge clk)
    cnt <= (rst || !enable || tc) ? '0 : base + 1'b1;
endmodule

// File: rtl/garage_door_actuator.sv
// garage_door_actuator: door plant model turning motor commands into position and limit switches
module garage_door_actuator
  import garage_door_pkg::*;
#(
  parameter int TRAVEL_STEPS = TRAVEL_STEPS_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  localparam int POS_W = $clog2(TRAVEL_STEPS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP_M,
  input  logic             DN_M,
  output logic             UP_Max,
  output logic             DN_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);
  localparam logic [POS_W-1:0] TOP = POS_W'(TRAVEL_STEPS);
  door_state_t state, ns, nxt;
  logic en, rev, step;
  logic [POS_W-1:0] pos_n;
  // next state from commands and current position; a step landing on a limit stops motion at once
  always_comb begin
    ns = (UP_M && DN_M) ? FAULT :
         (UP_M && Position != TOP) ? RAISING :
         (DN_M && Position != '0) ? LOWERING : IDLE;
    en = !RST && (ns == RAISING || ns == LOWERING);
    rev = (state == RAISING && ns == LOWERING) || (state == LOWERING && ns == RAISING);
    pos_n = !step ? Position : ns == RAISING ? Position + 1'b1 : Position - 1'b1;
    nxt = (step && (pos_n == TOP || pos_n == '0)) ? IDLE : ns;
  end
  door_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk(CLK),
    .rst(RST),
    .enable(en),
    .clear(rev),
    .tc(step)
  );
  // state, position and all outputs registered together so limits track the position edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      Position <= '0;
      UP_Max <= 1'b0;
      DN_Max <= 1'b1;
      Moving <= 1'b0;
      Fault <= 1'b0;
    end else begin
      state <= nxt;
      Position <= pos_n;
      UP_Max <= pos_n == TOP;
      DN_Max <= pos_n == '0;
      Moving <= nxt == RAISING || nxt == LOWERING;
      Fault <= ns == FAULT;
    end
  end
endmodule

// File: tb/tb_garage_door_actuator.sv
// tb_garage_door_actuator: directed and random checks of the door plant against a step-accumulator model
module tb_garage_door_actuator;
  localparam int T = 16;
  localparam int S = 4;
  logic CLK = 1'b0, RST = 1'b1, UP_M = 1'b0, DN_M = 1'b0;
  logic UP_Max, DN_Max, Moving, Fault;
  logic [4:0] Position;
  logic [8:0] obs;
  int checks = 0, errors = 0;
  int m_pos = 0, m_acc = 0, m_dir = 0;
  bit m_mov = 0, m_flt = 0;

  garage_door_actuator #(.TRAVEL_STEPS(T), .STEP_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .UP_M(UP_M), .DN_M(DN_M),
    .UP_Max(UP_Max), .DN_Max(DN_Max), .Position(Position),
    .Moving(Moving), .Fault(Fault)
  );

  always #5 CLK = ~CLK;
  assign obs = {Position, UP_Max, DN_Max, Moving, Fault};

  function automatic logic [8:0] exp_v();
    return {5'(m_pos), m_pos == T, m_pos == 0, m_mov, m_flt};
  endfunction

  // drive one edge and advance the model: drive cycles accumulate toward a step, anything else discards them
  task automatic tick(input bit u, input bit d, input bit r);
    int want;
    UP_M = u; DN_M = d; RST = r;
    @(posedge CLK); #1;
    if (r) begin
      m_pos = 0; m_acc = 0; m_dir = 0; m_mov = 0; m_flt = 0;
    end else if (u && d) begin
      m_flt = 1; m_acc = 0; m_dir = 0; m_mov = 0;
    end else begin
      want = (u && m_pos < T) ? 1 : (d && m_pos > 0) ? -1 : 0;
      m_flt = 0;
      if (want == 0) begin
        m_acc = 0; m_dir = 0; m_mov = 0;
      end else begin
        if (want != m_dir) m_acc = 0;
        m_dir = want;
        m_acc++;
        if (m_acc == S) begin
          m_pos += want; m_acc = 0;
          m_mov = m_pos != T && m_pos != 0;
        end else m_mov = 1;
      end
    end
  endtask

  task automatic test_reset();
    tick(1, 1, 1); tick(0, 0, 1);
    checks++;
    if (obs !== 9'b00000_0100) begin errors++; $display("FAIL reset obs=%b exp=%b", obs, 9'b00000_0100); end
  endtask

  task automatic test_open();
    for (int i = 1; i <= 64; i++) begin
      tick(1, 0, 0);
      checks++;
      if (obs !== exp_v()) begin errors++; $display("FAIL open c%0d obs=%b exp=%b", i, obs, exp_v()); end
      if (i == 4) begin
        checks++;
        if (Position !== 5'd1) begin errors++; $display("FAIL open_first_step pos=%0d exp=1", Position); end
      end
      if (i == 64) begin
        checks++;
        if ({Position, UP_Max, DN_Max, Moving} !== {5'd16, 3'b100}) begin
          errors++; $display("FAIL open_full obs=%b exp=%b", {Position, UP_Max, DN_Max, Moving}, {5'd16, 3'b100});
        end
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 20; i++) begin
      tick(1, 0, 0);
      checks++;
      if (obs !== exp_v() || Position !== 5'd16 || Moving !== 1'b0) begin
        errors++; $display("FAIL saturate c%0d obs=%b exp=%b", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_reversal();
    for (int i = 1; i <= 6; i++) begin
      tick(0, 1, 0);
      checks++;
      if (obs !== exp_v() || (i == 4 && Position !== 5'd15)) begin
        errors++; $display("FAIL rev_down c%0d obs=%b exp=%b", i, obs, exp_v());
      end
    end
    for (int i = 1; i <= 4; i++) begin
      tick(1, 0, 0);
      checks++;
      if (obs !== exp_v() || Position !== (i == 4 ? 5'd16 : 5'd15)) begin
        errors++; $display("FAIL rev_up c%0d obs=%b exp=%b", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_fault();
    tick(0, 0, 1);
    for (int i = 0; i < 32; i++) tick(1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 1, 0);
      checks++;
      if (obs !== exp_v() || Fault !== 1'b1 || Position !== 5'd8 || Moving !== 1'b0) begin
        errors++; $display("FAIL fault_hold c%0d obs=%b exp=%b", i, obs, exp_v());
      end
    end
    for (int i = 1; i <= 4; i++) begin
      tick(0, 1, 0);
      checks++;
      if (obs !== exp_v() || Fault !== 1'b0 || Position !== (i == 4 ? 5'd7 : 5'd8)) begin
        errors++; $display("FAIL fault_release c%0d obs=%b exp=%b", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 1);
    for (int i = 0; i < 38; i++) tick(1, 0, 0);
    checks++;
    if (Position !== 5'd9) begin errors++; $display("FAIL midreset_setup pos=%0d exp=9", Position); end
    tick(1, 0, 1);
    checks++;
    if (obs !== 9'b00000_0100) begin errors++; $display("FAIL midreset obs=%b exp=%b", obs, 9'b00000_0100); end
    for (int i = 1; i <= 4; i++) begin
      tick(1, 0, 0);
      checks++;
      if (obs !== exp_v()) begin errors++; $display("FAIL midreset_after c%0d obs=%b exp=%b", i, obs, exp_v()); end
    end
  endtask

  task automatic test_random();
    int cmd, len;
    for (int seg = 0; seg < 60; seg++) begin
      cmd = $urandom_range(0, 9);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        tick(cmd inside {[1:4], 8}, cmd inside {[5:8]}, $urandom_range(0, 199) == 0);
        checks++;
        if (obs !== exp_v()) begin errors++; $display("FAIL random s%0d c%0d obs=%b exp=%b", seg, i, obs, exp_v()); end
      end
    end
  endtask

  task automatic test_closed_loop();
    int n;
    tick(0, 0, 1);
    tick(0, 0, 0);
    n = 0;
    while (!UP_Max && n < 200) begin tick(1, 0, 0); n++; end
    tick(0, 0, 0);
    checks++;
    if (n !== 64 || Position !== 5'd16 || Moving !== 1'b0) begin
      errors++; $display("FAIL loop_open cycles=%0d pos=%0d exp 64/16", n, Position);
    end
    n = 0;
    while (!DN_Max && n < 200) begin tick(0, 1, 0); n++; end
    tick(0, 0, 0);
    checks++;
    if (n !== 64 || Position !== 5'd0 || UP_Max !== 1'b0 || obs !== exp_v()) begin
      errors++; $display("FAIL loop_close cycles=%0d pos=%0d exp 64/0", n, Position);
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_saturate();
    test_reversal();
    test_fault();
    test_reset_mid();
    test_random();
    test_closed_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
